// File: rtl/seg7_to_binary_scanner.sv
// seg7_to_binary_scanner
// Snoops a multiplexed 7-segment bus (segment lines plus one-hot digit select).
// Each digit dwell is debounced, decoded back to a 4-bit code and collected
// into a frame. The frame is presented on a valid/ready output port.
module seg7_to_binary_scanner #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] out_bcd,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic {ST_COLLECT, ST_WAIT} state_t;

  state_t                  state;
  logic [6:0]              sample_seg;
  logic [NUM_DIGITS-1:0]   sample_sel;
  logic [CW-1:0]           cnt;
  logic [NUM_DIGITS-1:0]   mask;
  logic [4*NUM_DIGITS-1:0] shadow_bcd;
  logic [NUM_DIGITS-1:0]   shadow_err;

  logic                    sel_onehot;
  logic                    same_pair;
  logic [CW-1:0]           cnt_next;
  logic                    capture;
  logic [3:0]              dec_code;
  logic                    dec_err;
  logic [NUM_DIGITS-1:0]   mask_cap;
  logic [4*NUM_DIGITS-1:0] shadow_bcd_cap;
  logic [NUM_DIGITS-1:0]   shadow_err_cap;

  // Map a segment pattern back to its digit code; blank is legal, anything else is an error.
  always_comb begin
    dec_err = 1'b0;
    case (seg_in)
      7'b1111110: dec_code = 4'd0;
      7'b0110000: dec_code = 4'd1;
      7'b1101101: dec_code = 4'd2;
      7'b1111001: dec_code = 4'd3;
      7'b0110011: dec_code = 4'd4;
      7'b1011011: dec_code = 4'd5;
      7'b1011111: dec_code = 4'd6;
      7'b1110000: dec_code = 4'd7;
      7'b1111111: dec_code = 4'd8;
      7'b1111011: dec_code = 4'd9;
      7'b0000000: dec_code = 4'hF;
      default: begin
        dec_code = 4'hE;
        dec_err  = 1'b1;
      end
    endcase
  end

  // Stability counter update and single capture pulse per dwell.
  always_comb begin
    sel_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - 1'b1)) == '0);
    same_pair  = (seg_in == sample_seg) && (dig_sel == sample_sel);
    if (!sel_onehot)
      cnt_next = '0;
    else if (same_pair && (cnt != '0))
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    else
      cnt_next = CW'(1);
    capture = (cnt_next == CNT_MAX) && (cnt != CNT_MAX);
  end

  // Shadow slots and mask as they would look after the capture on this edge.
  always_comb begin
    mask_cap       = mask | dig_sel;
    shadow_bcd_cap = shadow_bcd;
    shadow_err_cap = shadow_err;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_sel[i]) begin
        shadow_bcd_cap[4*i +: 4] = dec_code;
        shadow_err_cap[i]        = dec_err;
      end
    end
  end

  // Sampling, frame collection and output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_COLLECT;
      sample_seg <= '0;
      sample_sel <= '0;
      cnt        <= '0;
      mask       <= '0;
      shadow_bcd <= '0;
      shadow_err <= '0;
      out_bcd    <= '0;
      out_err    <= '0;
      out_valid  <= 1'b0;
    end else begin
      sample_seg <= seg_in;
      sample_sel <= dig_sel;
      if (!en) begin
        state      <= ST_COLLECT;
        cnt        <= '0;
        mask       <= '0;
        shadow_bcd <= '0;
        shadow_err <= '0;
        out_bcd    <= '0;
        out_err    <= '0;
        out_valid  <= 1'b0;
      end else begin
        cnt <= cnt_next;
        case (state)
          ST_COLLECT: begin
            if (capture) begin
              shadow_bcd <= shadow_bcd_cap;
              shadow_err <= shadow_err_cap;
              if (&mask_cap) begin
                out_bcd   <= shadow_bcd_cap;
                out_err   <= shadow_err_cap;
                out_valid <= 1'b1;
                mask      <= '0;
                state     <= ST_WAIT;
              end else begin
                mask <= mask_cap;
              end
            end
          end
          ST_WAIT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              state     <= ST_COLLECT;
            end
          end
          default: state <= ST_COLLECT;
        endcase
      end
    end
  end

endmodule
